load_store_unit: RTL and testbench



---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the pipeline request/response channel and the dataMem port of the load/store unit.
// "slave" is the LSU side, "master" the pipeline plus memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_writeenable;
  logic [31:0] mem_data;

  modport slave (
    input  req_valid, op, addr, wdata, mem_data,
    output req_ready, rsp_valid, rdata, fault, mem_address, mem_writedata, mem_writeenable
  );

  modport master (
    output req_valid, op, addr, wdata, mem_data,
    input  req_ready, rsp_valid, rdata, fault, mem_address, mem_writedata, mem_writeenable
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller for a word-wide, big-endian, byte-addressed data memory.
// Sub-word loads extract from an aligned word read; sub-word stores do read-modify-write.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  op_reg;
  logic [1:0]  off_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;
  logic [31:0] addr_reg;
  logic [31:0] rdata_reg;
  logic        fault_reg;
  logic        rsp_valid_reg;
  logic [31:0] merged_next;
  logic        legal_op;
  logic        fault_next;

  // op[1:0] encodes size (00 byte, 01 half, 11 word), op[2] unsigned, op[3] store.
  always_comb begin
    legal_op = 1'b0;
    case (bus.op)
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1011: legal_op = 1'b1;
      default:                   legal_op = 1'b0;
    endcase
    fault_next = !legal_op
              || (bus.op[1:0] == 2'b01 && bus.addr[0])
              || (bus.op[1:0] == 2'b11 && bus.addr[1:0] != 2'b00)
              || ({bus.addr[31:2], 2'b00} >= MEM_LIMIT);
  end

  function automatic logic [31:0] extract(input logic [3:0] o, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[31 - 8*off -: 8];
    h = off[1] ? w[15:0] : w[31:16];
    case (o[1:0])
      2'b00:   extract = o[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extract = o[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Byte lane gi is bits [31-8gi -: 8]; lane 0 is the lowest address (big-endian).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic byte_hit;
      logic half_hit;
      assign byte_hit = (op_reg[1:0] == 2'b00) && (off_reg == LANE);
      assign half_hit = (op_reg[1:0] == 2'b01) && (off_reg[1] == LANE[1]);
      assign merged_next[31 - 8*gi -: 8] =
          (op_reg[1:0] == 2'b11) ? wdata_reg[31 - 8*gi -: 8] :
          byte_hit               ? wdata_reg[7:0] :
          half_hit               ? (LANE[0] ? wdata_reg[7:0] : wdata_reg[15:8]) :
                                   word_reg[31 - 8*gi -: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= 4'h0;
      off_reg       <= 2'b00;
      wdata_reg     <= 32'h0;
      word_reg      <= 32'h0;
      addr_reg      <= 32'h0;
      rdata_reg     <= 32'h0;
      fault_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            op_reg    <= bus.op;
            off_reg   <= bus.addr[1:0];
            wdata_reg <= bus.wdata;
            addr_reg  <= {bus.addr[31:2], 2'b00};
            rdata_reg <= 32'h0;
            fault_reg <= fault_next;
            if (fault_next) begin
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else if (bus.op == 4'b1011) begin
              state_reg <= WRITE;
            end else begin
              state_reg <= READ;
            end
          end
        end
        READ: begin
          word_reg <= bus.mem_data;
          if (op_reg[3]) begin
            state_reg <= WRITE;
          end else begin
            rdata_reg     <= extract(op_reg, off_reg, bus.mem_data);
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        WRITE: begin
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write strobe and ready come straight from state so async reset kills them at once.
  assign bus.mem_writeenable = (state_reg == WRITE);
  assign bus.req_ready       = (state_reg == IDLE) && !reset;
  assign bus.mem_writedata   = merged_next;
  assign bus.mem_address     = addr_reg;
  assign bus.rdata           = rdata_reg;
  assign bus.fault           = fault_reg;
  assign bus.rsp_valid       = rsp_valid_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural big-endian word memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   wr_count = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256] = '{default: 32'h0};
  assign bus.mem_data = mem[bus.mem_address[9:2]];

  always @(posedge clk) begin
    if (bus.mem_writeenable) begin
      mem[bus.mem_address[9:2]] <= bus.mem_writedata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issues one request; cyc counts edges from accept (inclusive) to the first rsp_valid.
  task automatic do_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'h0, 32'h1);
    bus.req_valid = 1'b1;
    bus.op        = o;
    bus.addr      = a;
    bus.wdata     = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 32'h0, 32'h1);
    rd  = bus.rdata;
    flt = bus.fault;
    $display("[TB] op=%04b addr=%08h wdata=%08h -> rdata=%08h fault=%0b latency=%0d",
             o, a, wd, rd, flt, cyc);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] exp;
  } load_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } fault_vec_t;

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          cyc;
    int          wr_before;
    load_vec_t   loads [5];
    fault_vec_t  faults [4];

    loads[0] = '{4'b0011, 32'h10, 32'hDEADBEEF};
    loads[1] = '{4'b0000, 32'h10, 32'hFFFFFFDE};
    loads[2] = '{4'b0100, 32'h13, 32'h000000EF};
    loads[3] = '{4'b0001, 32'h12, 32'hFFFFBEEF};
    loads[4] = '{4'b0101, 32'h10, 32'h0000DEAD};
    faults[0] = '{4'b0011, 32'h11,  32'h55555555};
    faults[1] = '{4'b1001, 32'h13,  32'h0000FFFF};
    faults[2] = '{4'b0011, 32'h400, 32'h0};
    faults[3] = '{4'b0010, 32'h10,  32'h77777777};

    bus.req_valid = 1'b0;
    bus.op        = 4'h0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;

    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_fault", 32'(bus.fault), 32'h0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_mem_writedata", bus.mem_writedata, 32'h0);
    check("rst_mem_we", 32'(bus.mem_writeenable), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus.req_ready), 32'h1);

    // Seed a word, then abort an SB to it with reset during WRITE.
    do_req(4'b1011, 32'h20, 32'h11223344, rd, flt, cyc);
    check("sw20_latency", 32'(cyc), 32'd2);
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op        = 4'b1000;
    bus.addr      = 32'h21;
    bus.wdata     = 32'h99;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_write", 32'(bus.mem_writeenable), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_we_async", 32'(bus.mem_writeenable), 32'h0);
    check("abort_ready_low", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    check("abort_word", mem[8], 32'h11223344);
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_again", 32'(bus.req_ready), 32'h1);
    check("abort_no_rsp_after", 32'(bus.rsp_valid), 32'h0);
    $display("[TB] SB 0x21 aborted by reset during WRITE, word=%08h", mem[8]);
    do_req(4'b0011, 32'h20, 32'h0, rd, flt, cyc);
    check("abort_lw20", rd, 32'h11223344);

    do_req(4'b1011, 32'h10, 32'hDEADBEEF, rd, flt, cyc);
    check("sw10_latency", 32'(cyc), 32'd2);
    check("sw10_rdata", rd, 32'h0);
    check("sw10_fault", 32'(flt), 32'h0);

    foreach (loads[i]) begin
      do_req(loads[i].op, loads[i].addr, 32'h0, rd, flt, cyc);
      check($sformatf("load%0d_rdata", i), rd, loads[i].exp);
      check($sformatf("load%0d_fault", i), 32'(flt), 32'h0);
      check($sformatf("load%0d_latency", i), 32'(cyc), 32'd2);
    end

    do_req(4'b1000, 32'h11, 32'h00000012, rd, flt, cyc);
    check("sb11_latency", 32'(cyc), 32'd3);
    check("sb11_rdata", rd, 32'h0);
    do_req(4'b0011, 32'h10, 32'h0, rd, flt, cyc);
    check("sb11_word", rd, 32'hDE12BEEF);

    do_req(4'b1001, 32'h12, 32'h0000CAFE, rd, flt, cyc);
    check("sh12_latency", 32'(cyc), 32'd3);
    check("sh12_fault", 32'(flt), 32'h0);
    do_req(4'b0011, 32'h10, 32'h0, rd, flt, cyc);
    check("sh12_word", rd, 32'hDE12CAFE);

    foreach (faults[i]) begin
      wr_before = wr_count;
      do_req(faults[i].op, faults[i].addr, faults[i].wdata, rd, flt, cyc);
      check($sformatf("fault%0d_flag", i), 32'(flt), 32'h1);
      check($sformatf("fault%0d_rdata", i), rd, 32'h0);
      check($sformatf("fault%0d_latency", i), 32'(cyc), 32'd1);
      check($sformatf("fault%0d_writes", i), 32'(wr_count - wr_before), 32'h0);
      check($sformatf("fault%0d_word", i), mem[4], 32'hDE12CAFE);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
